// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one line-wide physical-memory port between the I-cache
// and D-cache miss/writeback paths. D-cache has priority; an anti-starvation
// streak counter forces the I-cache ahead after MAX_D_STREAK consecutive D
// grants taken while I was waiting. The granted request is latched at grant and
// memory is driven from those registers until pmem_resp.
// Optional build macro: CACHE_ARB_PERF_EN adds saturating grant/conflict
// counters and a perf_clear input.
module cache_arbiter #(
   parameter int ADDR_WIDTH   = 16,
   parameter int LINE_WIDTH   = 128,
   parameter int OFFSET_BITS  = 4,
   parameter int MAX_D_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_pmem_read,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
`ifdef CACHE_ARB_PERF_EN
   ,
   input  logic                  perf_clear,
   output logic [15:0]           perf_i_grants,
   output logic [15:0]           perf_d_grants,
   output logic [15:0]           perf_conflicts
`endif
);

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);
   localparam logic [3:0]            STREAK_MAX = 4'(MAX_D_STREAK);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

   state_t                r_state,        w_state_nxt;
   logic [3:0]            r_d_streak,     w_d_streak_nxt;
   logic                  r_pmem_read,    w_read_nxt;
   logic                  r_pmem_write,   w_write_nxt;
   logic [ADDR_WIDTH-1:0] r_pmem_address, w_address_nxt;
   logic [LINE_WIDTH-1:0] r_pmem_wdata,   w_wdata_nxt;
   logic                  w_req_i, w_req_d;
   logic                  w_grant_i, w_grant_d;

   assign w_req_i = i_pmem_read;
   assign w_req_d = d_pmem_read | d_pmem_write;

   // State register plus the latched copy of the granted memory request.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_d_streak     <= '0;
         r_pmem_read    <= 1'b0;
         r_pmem_write   <= 1'b0;
         r_pmem_address <= '0;
         r_pmem_wdata   <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_d_streak     <= w_d_streak_nxt;
         r_pmem_read    <= w_read_nxt;
         r_pmem_write   <= w_write_nxt;
         r_pmem_address <= w_address_nxt;
         r_pmem_wdata   <= w_wdata_nxt;
      end
   end

   // Arbitration, grant latching, streak update and completion back to IDLE.
   // NOTE: every variable gets a default first so no path leaves one unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_d_streak_nxt = r_d_streak;
      w_read_nxt     = r_pmem_read;
      w_write_nxt    = r_pmem_write;
      w_address_nxt  = r_pmem_address;
      w_wdata_nxt    = r_pmem_wdata;
      w_grant_i      = 1'b0;
      w_grant_d      = 1'b0;

      case (r_state)
         IDLE: begin
            // pmem_resp is ignored here: nothing is outstanding.
            if (w_req_d && !(w_req_i && (r_d_streak == STREAK_MAX))) w_grant_d = 1'b1;
            else if (w_req_i)                                       w_grant_i = 1'b1;
         end
         SERVE_I, SERVE_D: begin
            // Completion always passes through IDLE, so no back-to-back grants.
            if (pmem_resp) begin
               w_state_nxt   = IDLE;
               w_read_nxt    = 1'b0;
               w_write_nxt   = 1'b0;
               w_address_nxt = '0;
               w_wdata_nxt   = '0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if (w_grant_i) begin
         w_state_nxt    = SERVE_I;
         w_read_nxt     = 1'b1;
         w_write_nxt    = 1'b0;
         w_address_nxt  = i_pmem_address & LINE_MASK;
         w_wdata_nxt    = '0;
         w_d_streak_nxt = '0;
      end

      if (w_grant_d) begin
         w_state_nxt   = SERVE_D;
         w_read_nxt    = d_pmem_read;
         w_write_nxt   = d_pmem_write;
         w_address_nxt = d_pmem_address & LINE_MASK;
         w_wdata_nxt   = d_pmem_wdata;
         if (!w_req_i)                        w_d_streak_nxt = '0;
         else if (r_d_streak < STREAK_MAX)    w_d_streak_nxt = r_d_streak + 4'd1;
      end
   end

   assign pmem_read    = r_pmem_read;
   assign pmem_write   = r_pmem_write;
   assign pmem_address = r_pmem_address;
   assign pmem_wdata   = r_pmem_wdata;

   // Responses reach only the granted requester.
   assign i_pmem_resp  = pmem_resp & (r_state == SERVE_I);
   assign d_pmem_resp  = pmem_resp & (r_state == SERVE_D);
   assign i_pmem_rdata = (r_state == SERVE_I) ? pmem_rdata : '0;
   assign d_pmem_rdata = (r_state == SERVE_D) ? pmem_rdata : '0;

   // A D-cache read and writeback at once is a requester bug; it is forwarded as-is.
   a_d_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
      !(d_pmem_read && d_pmem_write))
      else $error("cache_arbiter: d_pmem_read and d_pmem_write both high");

`ifdef CACHE_ARB_PERF_EN
   logic        w_conflict;
   logic [15:0] r_perf_i, r_perf_d, r_perf_c;

   assign w_conflict = (r_state == IDLE) & w_req_i & w_req_d;

   // Saturating performance counters; clear dominates any same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset || perf_clear) begin
         r_perf_i <= '0;
         r_perf_d <= '0;
         r_perf_c <= '0;
      end else begin
         if (w_grant_i  && (r_perf_i != 16'hFFFF)) r_perf_i <= r_perf_i + 16'd1;
         if (w_grant_d  && (r_perf_d != 16'hFFFF)) r_perf_d <= r_perf_d + 16'd1;
         if (w_conflict && (r_perf_c != 16'hFFFF)) r_perf_c <= r_perf_c + 16'd1;
      end
   end

   assign perf_i_grants  = r_perf_i;
   assign perf_d_grants  = r_perf_d;
   assign perf_conflicts = r_perf_c;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: scoreboard bench for cache_arbiter. Tests queue the memory
// transactions and requester responses they expect; a memory model checks each
// new memory transaction and a monitor checks each forwarded response.
`timescale 1ns/1ps
module tb_cache_arbiter;

   localparam int MEM_LAT = 3;
   localparam int TIMEOUT = 100;

   typedef struct packed {
      logic         rd;
      logic         wr;
      logic [15:0]  addr;
      logic [127:0] wdata;
   } mem_txn_t;

   typedef struct packed {
      logic         is_d;
      logic [127:0] data;
   } resp_t;

   localparam logic [15:0]  ST_REQ  [5] = '{16'h3005, 16'h3015, 16'h3025, 16'h3035, 16'h3045};
   localparam logic [15:0]  ST_LINE [5] = '{16'h3000, 16'h3010, 16'h3020, 16'h3030, 16'h3040};
   localparam logic [127:0] WR_LINE     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   logic         clk = 1'b0;
   logic         reset;
   logic         i_pmem_read;
   logic [15:0]  i_pmem_address;
   logic [127:0] i_pmem_rdata;
   logic         i_pmem_resp;
   logic         d_pmem_read, d_pmem_write;
   logic [15:0]  d_pmem_address;
   logic [127:0] d_pmem_wdata, d_pmem_rdata;
   logic         d_pmem_resp;
   logic         pmem_read, pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;
`ifdef CACHE_ARB_PERF_EN
   logic         perf_clear;
   logic [15:0]  perf_i_grants, perf_d_grants, perf_conflicts;
`endif

   mem_txn_t     exp_mem_q [$];
   resp_t        exp_resp_q[$];
   int           n_compared   = 0;
   int           n_mismatched = 0;
   logic [127:0] mem_rdata    = '0;
   logic         inject_resp  = 1'b0;
   int           mem_cnt      = 0;

   cache_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_address (i_pmem_address),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp)
`ifdef CACHE_ARB_PERF_EN
      ,
      .perf_clear     (perf_clear),
      .perf_i_grants  (perf_i_grants),
      .perf_d_grants  (perf_d_grants),
      .perf_conflicts (perf_conflicts)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic exp_mem(input logic rd, input logic wr, input logic [15:0] addr, input logic [127:0] wdata);
      mem_txn_t t;
      t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata;
      exp_mem_q.push_back(t);
   endtask

   task automatic exp_resp(input logic is_d, input logic [127:0] data);
      resp_t r;
      r.is_d = is_d; r.data = data;
      exp_resp_q.push_back(r);
   endtask

   // Drive/check slot: 3 ns after the falling edge, well away from the rising edge.
   task automatic slot();
      @(negedge clk);
      #3;
   endtask

   // Memory model: checks each new transaction, answers after MEM_LAT strobe cycles.
   always @(negedge clk) begin
      mem_txn_t e;
      if (reset) begin
         mem_cnt = 0; pmem_resp = 1'b0; pmem_rdata = '0;
      end else if (inject_resp) begin
         pmem_resp = 1'b1; pmem_rdata = mem_rdata;
      end else if (pmem_read || pmem_write) begin
         if (mem_cnt == 0) begin
            if (exp_mem_q.size() == 0) begin
               n_compared++; n_mismatched++;
               $display("FAIL mem_txn: unexpected transaction rd=%b wr=%b addr=%h", pmem_read, pmem_write, pmem_address);
            end else begin
               e = exp_mem_q.pop_front();
               check("mem_read",  pmem_read,    e.rd);
               check("mem_write", pmem_write,   e.wr);
               check("mem_addr",  pmem_address, e.addr);
               check("mem_wdata", pmem_wdata,   e.wdata);
            end
         end
         mem_cnt++;
         if (mem_cnt == MEM_LAT) begin pmem_resp = 1'b1; pmem_rdata = mem_rdata; end
         else                    begin pmem_resp = 1'b0; pmem_rdata = '0;        end
      end else begin
         mem_cnt = 0; pmem_resp = 1'b0; pmem_rdata = '0;
      end
   end

   // Response monitor: every forwarded resp must match the next queued expectation.
   always @(negedge clk) begin
      resp_t r;
      #2;
      if (!reset && (i_pmem_resp || d_pmem_resp)) begin
         if (exp_resp_q.size() == 0) begin
            n_compared++; n_mismatched++;
            $display("FAIL resp: unexpected i_resp=%b d_resp=%b", i_pmem_resp, d_pmem_resp);
         end else begin
            r = exp_resp_q.pop_front();
            check("resp_i",           i_pmem_resp, !r.is_d);
            check("resp_d",           d_pmem_resp, r.is_d);
            check("resp_rdata",       r.is_d ? d_pmem_rdata : i_pmem_rdata, r.data);
            check("resp_other_rdata", r.is_d ? i_pmem_rdata : d_pmem_rdata, '0);
         end
      end
   end

   task automatic i_req(input logic [15:0] addr);
      int n;
      logic seen;
      n = 0; seen = 1'b0;
      i_pmem_read = 1'b1; i_pmem_address = addr;
      while (!seen && n < TIMEOUT) begin slot(); seen = i_pmem_resp; n++; end
      check("i_resp_seen", seen, 1'b1);
      i_pmem_read = 1'b0;
      slot();
   endtask

   task automatic d_req(input logic rd, input logic wr, input logic [15:0] addr, input logic [127:0] wdata);
      int n;
      logic seen;
      n = 0; seen = 1'b0;
      d_pmem_read = rd; d_pmem_write = wr; d_pmem_address = addr; d_pmem_wdata = wdata;
      while (!seen && n < TIMEOUT) begin slot(); seen = d_pmem_resp; n++; end
      check("d_resp_seen", seen, 1'b1);
      d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_wdata = '0;
      slot();
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_pmem_read"},    pmem_read,    '0);
      check({tag, "_pmem_write"},   pmem_write,   '0);
      check({tag, "_pmem_address"}, pmem_address, '0);
      check({tag, "_pmem_wdata"},   pmem_wdata,   '0);
      check({tag, "_i_resp"},       i_pmem_resp,  '0);
      check({tag, "_d_resp"},       d_pmem_resp,  '0);
      check({tag, "_i_rdata"},      i_pmem_rdata, '0);
      check({tag, "_d_rdata"},      d_pmem_rdata, '0);
   endtask

   initial begin
      int   n;
      logic seen;
      reset = 1'b1;
      i_pmem_read = 1'b0; i_pmem_address = '0;
      d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
`ifdef CACHE_ARB_PERF_EN
      perf_clear = 1'b0;
`endif
      repeat (3) slot();
      check_quiet("reset");
`ifdef CACHE_ARB_PERF_EN
      check("reset_perf_i", perf_i_grants,  '0);
      check("reset_perf_d", perf_d_grants,  '0);
      check("reset_perf_c", perf_conflicts, '0);
`endif
      reset = 1'b0;
      slot();

      // I-only line fill, unaligned address.
      mem_rdata = {16{8'hA5}};
      exp_mem(1'b1, 1'b0, 16'h1230, '0);
      exp_resp(1'b0, {16{8'hA5}});
      i_req(16'h1237);
      check("i_only_idle", pmem_read, 1'b0);

`ifdef CACHE_ARB_PERF_EN
      perf_clear = 1'b1; slot(); perf_clear = 1'b0;
`endif

      // Simultaneous I read and D writeback: D first, then I.
      mem_rdata = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
      exp_mem(1'b0, 1'b1, 16'h4000, WR_LINE);
      exp_mem(1'b1, 1'b0, 16'h1110, '0);
      exp_resp(1'b1, 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F);
      exp_resp(1'b0, 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F);
      fork
         i_req(16'h1111);
         d_req(1'b0, 1'b1, 16'h4000, WR_LINE);
      join

      // Starvation: I held while D re-requests; 4 D grants, then I, then the last D.
      mem_rdata = 128'h3C3C_3C3C_3C3C_3C3C_3C3C_3C3C_3C3C_3C3C;
      for (int k = 0; k < 4; k++) begin
         exp_mem(1'b1, 1'b0, ST_LINE[k], '0);
         exp_resp(1'b1, 128'h3C3C_3C3C_3C3C_3C3C_3C3C_3C3C_3C3C_3C3C);
      end
      exp_mem(1'b1, 1'b0, 16'h5A50, '0);
      exp_resp(1'b0, 128'h3C3C_3C3C_3C3C_3C3C_3C3C_3C3C_3C3C_3C3C);
      exp_mem(1'b1, 1'b0, ST_LINE[4], '0);
      exp_resp(1'b1, 128'h3C3C_3C3C_3C3C_3C3C_3C3C_3C3C_3C3C_3C3C);
      fork
         i_req(16'h5A5F);
         begin
            for (int k = 0; k < 5; k++) d_req(1'b1, 1'b0, ST_REQ[k], '0);
         end
      join

`ifdef CACHE_ARB_PERF_EN
      // Since the clear: conflicts 1+5, I grants 1+1, D grants 1+5.
      check("perf_conflicts", perf_conflicts, 16'd6);
      check("perf_i_grants",  perf_i_grants,  16'd2);
      check("perf_d_grants",  perf_d_grants,  16'd6);
      perf_clear = 1'b1; slot(); perf_clear = 1'b0;
      check("perf_clr_c", perf_conflicts, '0);
      check("perf_clr_i", perf_i_grants,  '0);
      check("perf_clr_d", perf_d_grants,  '0);
`endif

      // Streak was cleared: a fresh conflict goes to D first again.
      mem_rdata = 128'h1;
      exp_mem(1'b1, 1'b0, 16'h0200, '0);
      exp_mem(1'b1, 1'b0, 16'h0100, '0);
      exp_resp(1'b1, 128'h1);
      exp_resp(1'b0, 128'h1);
      fork
         i_req(16'h0100);
         d_req(1'b1, 1'b0, 16'h0200, '0);
      join

      // Requester abort: D drops its read right after grant; memory strobe holds.
      mem_rdata = 128'h55AA_55AA_55AA_55AA_55AA_55AA_55AA_55AA;
      exp_mem(1'b1, 1'b0, 16'h2460, '0);
      exp_resp(1'b1, 128'h55AA_55AA_55AA_55AA_55AA_55AA_55AA_55AA);
      d_pmem_read = 1'b1; d_pmem_address = 16'h2468;
      n = 0; seen = 1'b0;
      while (!seen && n < TIMEOUT) begin slot(); seen = pmem_read; n++; end
      check("abort_grant", seen, 1'b1);
      d_pmem_read = 1'b0;
      n = 0; seen = 1'b0;
      while (!seen && n < TIMEOUT) begin
         slot(); seen = d_pmem_resp; n++;
         check("abort_strobe_held", pmem_read, 1'b1);
      end
      check("abort_resp_seen", seen, 1'b1);
      slot();
      check("abort_idle_read", pmem_read, 1'b0);
      check("abort_idle_resp", d_pmem_resp, 1'b0);

      // Reset in the middle of SERVE_I, then a stray pmem_resp in IDLE.
      exp_mem(1'b1, 1'b0, 16'h7770, '0);
      i_pmem_read = 1'b1; i_pmem_address = 16'h7777;
      n = 0; seen = 1'b0;
      while (!seen && n < TIMEOUT) begin slot(); seen = pmem_read; n++; end
      check("rst_grant", seen, 1'b1);
      reset = 1'b1; i_pmem_read = 1'b0;
      slot();
      reset = 1'b0;
      check_quiet("midrst");
      mem_rdata = '1;
      inject_resp = 1'b1;
      slot();
      check("stray_resp_seen_by_dut", pmem_resp, 1'b1);
      check("stray_i_resp",  i_pmem_resp,  1'b0);
      check("stray_d_resp",  d_pmem_resp,  1'b0);
      check("stray_i_rdata", i_pmem_rdata, '0);
      check("stray_d_rdata", d_pmem_rdata, '0);
      inject_resp = 1'b0;
      slot();
      check("stray_stay_idle", pmem_read, 1'b0);

      repeat (3) slot();
      check("mem_q_drained",  exp_mem_q.size(),  0);
      check("resp_q_drained", exp_resp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
